led_rate_counter: RTL and testbench
===================================

Name: led_rate_counter

Overview:
Parametrised successor to the board's one-second LED counter. A single-clock-domain prescaler generates a one-cycle tick enable; there is no derived clock. The tick is selectable among four rates. A WIDTH-bit counter advances on each tick and supports up/down counting, hold, parallel load, and wrap or saturate at the bounds. It sits between the button/switch logic and the LED pins, and drives LED[6:0] directly when WIDTH=7.

Parameters:
CLK_HZ, 30000000, clk30 frequency in Hz
TICK_HZ, 1, base tick rate in Hz at rate_sel=0; CLK_HZ/(TICK_HZ*8) must be an integer >= 1
WIDTH, 7, counter width
SATURATE, 0, 0 = wrap at bounds; 1 = hold at bound

Ports:
clk30  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  1 = run; 0 = freeze prescaler and counter
dir  input  1  0 = count up; 1 = count down
rate_sel  input  2  tick period = CLK_HZ/(TICK_HZ<<rate_sel) cycles
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  current count (to LEDs)
tick  output  1  one-cycle pulse, high in the cycle count first shows a tick-advanced value
wrap  output  1  one-cycle pulse coincident with tick when count wrapped, or hit a bound with SATURATE=1

Behaviour:
- Reset (async, rst=1): pre_cnt=0, count=0, tick=0, wrap=0, rate_q=0. These values hold for as long as rst is high.
- Prescaler: pre_cnt counts 0..P-1, where P = CLK_HZ/(TICK_HZ<<rate_q).
  - Internal tick_i = en && (pre_cnt==P-1).
  - On tick_i, pre_cnt returns to 0.
  - pre_cnt width is $clog2(CLK_HZ/TICK_HZ).
- rate_sel is registered into rate_q.
  - If rate_sel != rate_q, then on that edge rate_q <= rate_sel, pre_cnt <= 0, and no tick_i occurs that cycle.
- en=0: pre_cnt, count and rate_q all hold; tick=wrap=0. load still acts.
- Priority on each edge, highest first: load > tick_i > hold.
  - load=1: count <= load_val; pre_cnt <= 0; tick and wrap are 0 next cycle. A simultaneous tick_i is discarded.
  - tick_i with dir=0:
    - count != max: count+1.
    - count == max (2^WIDTH-1): SATURATE=0 gives 0; SATURATE=1 holds max. wrap=1 in both cases.
  - tick_i with dir=1:
    - count != 0: count-1.
    - count == 0: SATURATE=0 gives max; SATURATE=1 holds 0. wrap=1 in both cases.
- tick and wrap are registered outputs, high for exactly one cycle. They are high the cycle after the tick_i edge, aligned with the new count.
- dir is sampled only on the tick_i edge. A change between ticks takes effect at the next tick with no glitch.
- Steady state: tick period is exactly P cycles; the first tick after reset or load arrives P cycles later.
- Reset mid-operation: immediate return to the reset values. After rst falls, the first tick follows P0 = CLK_HZ/TICK_HZ cycles.
- Back-to-back load every cycle: no tick is ever produced.

Decomposition:
- Package led_pkg holds:
  - localparam CLK30_HZ = 30000000.
  - Rate-select encodings RATE_1X/2X/4X/8X = 2'd0..3.
- Sub-module tick_gen (CLK_HZ, TICK_HZ):
  - Inputs: clk30, rst, en, rate_sel, clr.
  - Output: tick_i.
  - Owns pre_cnt and rate_q.
  - clr is driven by load.
- The top module holds the count, tick and wrap registers.

Test Plan:
Use CLK_HZ=16, TICK_HZ=1, WIDTH=4 unless noted.
1. Reset, en=1, dir=0, rate_sel=0 -> first tick on cycle 16 after rst release, count=1; ticks every 16 cycles; count 15->0 with wrap=1 coincident with tick.
2. rate_sel changes 0->3 mid-period -> no tick on change cycle; thereafter ticks every 2 cycles; 0->2 gives every 4 cycles.
3. dir=1 from count=0, SATURATE=0 -> next tick count=15, wrap=1; SATURATE=1 instance -> count stays 0, wrap=1 each tick, tick still pulses.
4. load=1, load_val=9 on the same edge as tick_i -> count=9, tick=0, wrap=0; next tick exactly 16 cycles later, count=10.
5. en=0 for 40 cycles at pre_cnt=10 -> count frozen, no tick; after en=1, tick after 6 more cycles.
6. rst asserted asynchronously mid-period with count=7 -> count=0, tick=0 immediately, without waiting for a clock edge; default params (30 MHz, 1 Hz, WIDTH=7) spot check: tick period 30,000,000 cycles.

Source files
------------

// File: rtl/led_rate_counter_pkg.sv
// Shared constants for the LED rate counter: board clock frequency and the
// rate-select encodings used by the switch logic and the tick generator.
package led_pkg;

  // Board clock feeding clk30.
  localparam int unsigned CLK30_HZ = 30000000;

  // Rate-select encodings: tick rate is the base rate shifted left by rate_sel.
  localparam logic [1:0] RATE_1X = 2'd0;
  localparam logic [1:0] RATE_2X = 2'd1;
  localparam logic [1:0] RATE_4X = 2'd2;
  localparam logic [1:0] RATE_8X = 2'd3;

  // Prescaler period in clk30 cycles for a given rate. base_cycles is
  // CLK_HZ/TICK_HZ, which is a multiple of 8, so the shift is exact.
  function automatic int unsigned period_cycles(input int unsigned base_cycles,
                                                input logic [1:0]  rate);
    return base_cycles >> rate;
  endfunction

endpackage

// File: rtl/led_rate_counter_tick_gen.sv
// Prescaler for the LED rate counter. Produces a one-cycle tick enable every
// P = CLK_HZ/(TICK_HZ<<rate_q) cycles of clk30; no derived clock is created.
// A change on rate_sel restarts the period, and clr (driven by the parallel
// load) restarts it as well, even while the prescaler is frozen by en=0.
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK30_HZ,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       clk30,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] rate_sel,
  input  logic       clr,
  output logic       tick_i
);

  // Cycles per tick at the slowest rate; sets the prescaler width.
  localparam int unsigned P0 = CLK_HZ / TICK_HZ;
  localparam int unsigned PW = (P0 > 1) ? $clog2(P0) : 1;

  logic [PW-1:0] pre_cnt_q;
  logic [PW-1:0] pre_cnt_d;
  logic [1:0]    rate_q;
  logic [1:0]    rate_d;
  logic [PW-1:0] last_cnt;
  logic          rate_change;
  logic          at_last;

  // Terminal count for the currently active rate and the tick decision.
  always_comb begin
    last_cnt    = PW'(period_cycles(P0, rate_q) - 1);
    rate_change = (rate_sel != rate_q);
    at_last     = (pre_cnt_q == last_cnt);
    // A rate change swallows the tick that would otherwise fall on this edge.
    tick_i      = en && !rate_change && at_last;
  end

  // Next prescaler count and registered rate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which is what would otherwise infer a latch.
    pre_cnt_d = pre_cnt_q;
    rate_d    = rate_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      if (rate_change || at_last) begin
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
    if (en && rate_change) begin
      rate_d = rate_sel;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk30 or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (rst) begin
      pre_cnt_q <= '0;
      rate_q    <= RATE_1X;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      rate_q    <= rate_d;
    end
  end

endmodule

// File: rtl/led_rate_counter.sv
// LED rate counter: a WIDTH-bit up/down counter advanced by a selectable-rate
// tick from tick_gen. Supports hold (en=0), parallel load, and wrap or
// saturate at the bounds. tick and wrap are registered one-cycle pulses that
// line up with the count value they announce.
module led_rate_counter
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = CLK30_HZ,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned WIDTH    = 7,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk30,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       rate_sel,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  logic             tick_i;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_q;
  logic             tick_d;
  logic             wrap_q;
  logic             wrap_d;

  // The load strobe also restarts the prescaler so the next tick is a full
  // period after the load.
  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk30    (clk30),
    .rst      (rst),
    .en       (en),
    .rate_sel (rate_sel),
    .clr      (load),
    .tick_i   (tick_i)
  );

  // Next count with load > tick > hold priority; dir only matters on a tick.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick_i) begin
      tick_d = 1'b1;
      if (!dir) begin
        if (count_q == MAX_VAL) begin
          wrap_d  = 1'b1;
          count_d = SATURATE ? MAX_VAL : MIN_VAL;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == MIN_VAL) begin
          wrap_d  = 1'b1;
          count_d = SATURATE ? MIN_VAL : MAX_VAL;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Count and pulse registers; all are cleared and held by rst.
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_led_rate_counter.sv
// Bench for led_rate_counter: a wrapping and a saturating 16 Hz / 1 Hz / 4-bit
// instance share stimulus and are compared every cycle against an arithmetic
// reference model; directed scenarios add fixed expectations on top. A third
// instance with default parameters is spot-checked for reset and no early tick.
module tb_led_rate_counter;

  localparam int P0   = 16;
  localparam int MAXV = 15;

  logic       clk30    = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b1;
  logic       dir      = 1'b0;
  logic       load     = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count_w, count_s;
  logic       tick_w, tick_s, wrap_w, wrap_s;
  logic [6:0] count_dflt;
  logic       tick_dflt, wrap_dflt;

  int errors = 0;
  int checks = 0;
  int dflt_ticks = 0;

  // Reference model state: phase within the current period, active rate,
  // counts for the wrapping [0] and saturating [1] instances, expected pulses.
  int m_phase, m_rate;
  int m_cnt [2];
  bit m_tick;
  bit m_wrap [2];

  always #5 clk30 = ~clk30;

  led_rate_counter #(.CLK_HZ(16), .TICK_HZ(1), .WIDTH(4), .SATURATE(1'b0)) dut_w (
    .clk30(clk30), .rst(rst), .en(en), .dir(dir), .rate_sel(rate_sel),
    .load(load), .load_val(load_val), .count(count_w), .tick(tick_w), .wrap(wrap_w));

  led_rate_counter #(.CLK_HZ(16), .TICK_HZ(1), .WIDTH(4), .SATURATE(1'b1)) dut_s (
    .clk30(clk30), .rst(rst), .en(en), .dir(dir), .rate_sel(rate_sel),
    .load(load), .load_val(load_val), .count(count_s), .tick(tick_s), .wrap(wrap_s));

  led_rate_counter dut_dflt (
    .clk30(clk30), .rst(rst), .en(1'b1), .dir(1'b0), .rate_sel(2'd0),
    .load(1'b0), .load_val(7'd0), .count(count_dflt), .tick(tick_dflt), .wrap(wrap_dflt));

  always @(negedge clk30) if (tick_dflt === 1'b1) dflt_ticks++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rate = 0; m_tick = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_wrap[0] = 0; m_wrap[1] = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at the edge.
  task automatic model_edge();
    int  period, nxt;
    bit  fire, rchg;
    if (rst) begin
      model_reset();
      return;
    end
    period = P0 >> m_rate;
    rchg   = (int'(rate_sel) != m_rate);
    fire   = en && !rchg && (m_phase == period - 1);
    m_tick = 0; m_wrap[0] = 0; m_wrap[1] = 0;
    if (load) begin
      m_cnt[0] = int'(load_val);
      m_cnt[1] = int'(load_val);
    end else if (fire) begin
      m_tick = 1;
      for (int s = 0; s < 2; s++) begin
        nxt = m_cnt[s] + (dir ? -1 : 1);
        if (nxt < 0 || nxt > MAXV) begin
          m_wrap[s] = 1;
          m_cnt[s]  = (s == 1) ? m_cnt[s] : (nxt + MAXV + 1) % (MAXV + 1);
        end else begin
          m_cnt[s] = nxt;
        end
      end
    end
    if (load || (en && (fire || rchg))) m_phase = 0;
    else if (en)                         m_phase = m_phase + 1;
    if (en && rchg) m_rate = int'(rate_sel);
  endtask

  task automatic compare_all();
    check("count_wrapinst", count_w, m_cnt[0]);
    check("tick_wrapinst",  tick_w,  m_tick);
    check("wrap_wrapinst",  wrap_w,  m_wrap[0]);
    check("count_satinst",  count_s, m_cnt[1]);
    check("tick_satinst",   tick_s,  m_tick);
    check("wrap_satinst",   wrap_s,  m_wrap[1]);
  endtask

  // Advance one edge, update the model, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk30);
    model_edge();
    #1;
    compare_all();
  endtask

  // Run n cycles; report the number of ticks seen and the index of the first.
  task automatic run(input int n, output int ticks, output int first);
    ticks = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (tick_w === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int t, f;
    model_reset();

    // Reset held: outputs stay at their reset values across edges.
    #2;
    check("reset_count_async", count_w, 0);
    cycle();
    cycle();
    check("reset_tick", tick_w, 0);

    // 1. First tick 16 cycles after release, then wrap 15->0.
    rst = 1'b0;
    run(16, t, f);
    check("first_tick_cycle", f, 16);
    check("first_tick_count", count_w, 1);
    run(16 * 14, t, f);
    check("ticks_in_14_periods", t, 14);
    check("count_before_wrap", count_w, 15);
    run(16, t, f);
    check("wrap_count", count_w, 0);
    check("wrap_pulse", wrap_w, 1);
    check("wrap_tick", tick_w, 1);
    check("sat_hold_max", count_s, 15);
    check("sat_wrap_pulse", wrap_s, 1);

    // 2. Rate changes mid-period.
    run(5, t, f);
    rate_sel = 2'd3;
    cycle();
    check("rate3_change_notick", tick_w, 0);
    run(8, t, f);
    check("rate3_ticks", t, 4);
    check("rate3_first", f, 2);
    rate_sel = 2'd2;
    cycle();
    check("rate2_change_notick", tick_w, 0);
    run(16, t, f);
    check("rate2_ticks", t, 4);
    check("rate2_first", f, 4);

    // 3. Count down from 0: wrap to max vs. saturate at 0.
    rate_sel = 2'd0; load = 1'b1; load_val = 4'd0; dir = 1'b1;
    cycle();
    load = 1'b0;
    run(16, t, f);
    check("down_first", f, 16);
    check("down_wrap_count", count_w, 15);
    check("down_wrap_pulse", wrap_w, 1);
    check("down_sat_count", count_s, 0);
    check("down_sat_pulse", wrap_s, 1);
    check("down_sat_tick", tick_s, 1);
    run(16, t, f);
    check("down_sat_again", wrap_s, 1);
    check("down_step_count", count_w, 14);

    // 4. Load on the same edge as a tick.
    run(15, t, f);
    load = 1'b1; load_val = 4'd9; dir = 1'b0;
    cycle();
    check("load_tick_count", count_w, 9);
    check("load_tick_suppressed", tick_w, 0);
    check("load_wrap_suppressed", wrap_w, 0);
    load = 1'b0;
    run(16, t, f);
    check("after_load_first", f, 16);
    check("after_load_ticks", t, 1);
    check("after_load_count", count_w, 10);

    // 5. Freeze at pre_cnt=10 for 40 cycles.
    run(10, t, f);
    en = 1'b0;
    run(40, t, f);
    check("frozen_ticks", t, 0);
    check("frozen_count", count_w, 10);
    en = 1'b1;
    run(6, t, f);
    check("resume_first", f, 6);
    check("resume_count", count_w, 11);

    // 6. Async reset mid-period with count=7.
    load = 1'b1; load_val = 4'd7;
    cycle();
    load = 1'b0;
    run(5, t, f);
    check("pre_reset_count", count_w, 7);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_count", count_w, 0);
    check("async_reset_tick", tick_w, 0);
    check("async_reset_sat_count", count_s, 0);
    model_reset();
    cycle();
    rst = 1'b0;
    run(16, t, f);
    check("post_reset_first", f, 16);
    check("post_reset_count", count_w, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) dir = $urandom_range(0, 1);
      if ($urandom_range(0, 99) == 0) rate_sel = 2'($urandom_range(0, 3));
      load     = ($urandom_range(0, 39) == 0);
      load_val = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    // Default-parameter instance: 30M-cycle period means no tick in this run.
    check("dflt_no_tick", dflt_ticks, 0);
    check("dflt_count", count_dflt, 0);
    check("dflt_wrap", wrap_dflt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
